// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit datapath PC/branch logic.
package cpu_pkg;

    localparam int PC_W    = 16;
    localparam int PC_STEP = 2;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/branch_target_calc.sv
// Redirect target: jump (bit 0 forced low) or branch PC + 2 + offset*2.
import cpu_pkg::*;

module branch_target_calc #(
    parameter int WIDTH = PC_W
) (
    input  logic             jump_valid,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] branch_pc,
    input  logic [WIDTH-1:0] offset,
    output logic [WIDTH-1:0] target
);

    always_comb begin
        target = '0;
        if (jump_valid)
            target = jump_target & ~WIDTH'(1);
        else
            target = branch_pc + WIDTH'(PC_STEP) + (offset << 1);
    end

endmodule

// File: rtl/branch_pc_unit.sv
// PC register, beq/bne/jump redirect and post-redirect flush sequencing.
// Optional BRANCH_STATS_EN adds a saturating TakenCount output.
import cpu_pkg::*;

module branch_pc_unit #(
    parameter int               WIDTH        = PC_W,
    parameter int               FLUSH_CYCLES = 2,
    parameter logic [WIDTH-1:0] RESET_PC     = '0
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Stall,
    input  logic             BranchValid,
    input  logic             BranchEq,
    input  logic             Equal,
    input  logic [WIDTH-1:0] BranchPC,
    input  logic [WIDTH-1:0] Offset,
    input  logic             JumpValid,
    input  logic [WIDTH-1:0] JumpTarget,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCPlus2,
    output logic             Flush,
    output logic             Taken
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]      TakenCount
`endif
);

    state_t           state;
    logic [2:0]       cnt;
    logic [WIDTH-1:0] target;
    logic             redirect;

    branch_target_calc #(.WIDTH(WIDTH)) u_target (
        .jump_valid  (JumpValid),
        .jump_target (JumpTarget),
        .branch_pc   (BranchPC),
        .offset      (Offset),
        .target      (target)
    );

    assign redirect = (state == RUN) && !Stall &&
                      (JumpValid || (BranchValid && (Equal == BranchEq)));

    assign PCPlus2 = PC + WIDTH'(PC_STEP);
    assign Flush   = (state == FLUSH);

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            PC    <= RESET_PC;
            state <= RUN;
            cnt   <= '0;
            Taken <= 1'b0;
        end else begin
            Taken <= redirect;
            unique case (state)
                RUN: begin
                    if (redirect) begin
                        PC    <= target;
                        state <= FLUSH;
                        cnt   <= 3'(FLUSH_CYCLES - 1);
                    end else if (!Stall) begin
                        PC <= PCPlus2;
                    end
                end
                FLUSH: begin
                    // Counter runs even under Stall so flush length is fixed.
                    if (!Stall)
                        PC <= PCPlus2;
                    if (cnt == '0)
                        state <= RUN;
                    else
                        cnt <= cnt - 3'd1;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n)
            TakenCount <= '0;
        else if (redirect && (TakenCount != 16'hFFFF))
            TakenCount <= TakenCount + 16'd1;
    end
`endif

endmodule
